// File: rtl/snake_pkg.sv
`default_nettype none
// snake_pkg: direction encodings, FSM states, default colours and the direction-reverse helper
// shared by the snake engine files (rev 1.0).
package snake_pkg;

   localparam logic [1:0] DIR_LEFT  = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_UP    = 2'd2;
   localparam logic [1:0] DIR_DOWN  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALC  = 3'd1,
      S_CHECK = 3'd2,
      S_ERASE = 3'd3,
      S_WRITE = 3'd4,
      S_DRAW  = 3'd5,
      S_DONE  = 3'd6,
      S_OVER  = 3'd7
   } state_t;

   localparam logic [2:0] DEF_HEAD_COLOUR = 3'b001;
   localparam logic [2:0] DEF_BG_COLOUR   = 3'b111;

   // Opposite directions differ only in bit 0, so reversal is a single bit flip.
   function automatic logic [1:0] reverse_dir(input logic [1:0] d);
      return {d[1], ~d[0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/snake_ring_buf.sv
`default_nettype none
// snake_ring_buf: body segment storage, one write port and one registered read port (rev 1.0).
module snake_ring_buf #(
   parameter int DEPTH = 128,
   parameter int W     = 15,
   parameter int AW    = 7
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata <= mem_q[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/snake_engine.sv
`default_nettype none
// snake_engine: ring-buffer snake body with move FSM, wall/self collision, growth and pixel requests (rev 1.0).
// Define SNAKE_WRAP_EN to make the playfield edges wrap instead of ending the game.
module snake_engine
   import snake_pkg::*;
#(
   parameter int         X_W         = 8,
   parameter int         Y_W         = 7,
   parameter int         MAX_LEN     = 128,
   parameter int         X_MIN       = 48,
   parameter int         X_MAX       = 112,
   parameter int         Y_MIN       = 28,
   parameter int         Y_MAX       = 92,
   parameter int         START_X     = 80,
   parameter int         START_Y     = 60,
   parameter logic [2:0] HEAD_COLOUR = DEF_HEAD_COLOUR,
   parameter logic [2:0] BG_COLOUR   = DEF_BG_COLOUR
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     step,
   input  logic [1:0]               dir,
   input  logic                     grow,
   input  logic                     restart,
   output logic                     busy,
   output logic                     done,
   output logic                     over,
   output logic [$clog2(MAX_LEN):0] length,
   output logic [X_W-1:0]           head_x,
   output logic [Y_W-1:0]           head_y,
   output logic                     draw_valid,
   input  logic                     draw_ready,
   output logic [X_W-1:0]           draw_x,
   output logic [Y_W-1:0]           draw_y,
   output logic [2:0]               draw_colour
);

   localparam int PTR_W = $clog2(MAX_LEN);
   localparam int LEN_W = PTR_W + 1;
   localparam int SEG_W = X_W + Y_W;

   localparam logic [X_W-1:0]   X_MIN_C   = X_W'(X_MIN);
   localparam logic [X_W-1:0]   X_MAX_C   = X_W'(X_MAX);
   localparam logic [Y_W-1:0]   Y_MIN_C   = Y_W'(Y_MIN);
   localparam logic [Y_W-1:0]   Y_MAX_C   = Y_W'(Y_MAX);
   localparam logic [X_W-1:0]   START_X_C = X_W'(START_X);
   localparam logic [Y_W-1:0]   START_Y_C = Y_W'(START_Y);
   localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

`ifdef SNAKE_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   state_t            state_q, state_d;
   logic [1:0]        dir_q, dir_d;
   logic              grow_q, grow_d;
   logic [PTR_W-1:0]  head_ptr_q, head_ptr_d;
   logic [LEN_W-1:0]  length_q, length_d;
   logic [X_W-1:0]    head_x_q, head_x_d, next_x_q, next_x_d;
   logic [Y_W-1:0]    head_y_q, head_y_d, next_y_q, next_y_d;
   logic [PTR_W-1:0]  chk_ptr_q, chk_ptr_d;
   logic [LEN_W-1:0]  chk_left_q, chk_left_d;
   logic              done_q, done_d;

   logic              restart_ok, init;
   logic [PTR_W-1:0]  tail_ptr;
   logic [LEN_W-1:0]  chk_count;
   logic [X_W-1:0]    mv_x;
   logic [Y_W-1:0]    mv_y;
   logic              at_wall, wall_over, seg_match;
   logic              wr_en;
   logic [PTR_W-1:0]  wr_addr, rd_addr;
   logic [SEG_W-1:0]  wr_data, rd_data;

   assign restart_ok = restart && (state_q == S_IDLE || state_q == S_OVER);
   assign init       = !resetn || restart_ok;
   assign tail_ptr   = head_ptr_q - length_q[PTR_W-1:0] + PTR_W'(1);
   // A non-growing move vacates the tail, so the head may legally enter it.
   assign chk_count  = grow_q ? length_q : length_q - LEN_W'(1);
   assign seg_match  = (rd_data == {next_x_q, next_y_q});
   assign wall_over  = at_wall && !WRAP_EN;

   always_comb begin
      mv_x    = head_x_q;
      mv_y    = head_y_q;
      at_wall = 1'b0;
      case (dir_q)
         DIR_LEFT: begin
            at_wall = (head_x_q == X_MIN_C);
            mv_x    = at_wall ? X_MAX_C : head_x_q - X_W'(1);
         end
         DIR_RIGHT: begin
            at_wall = (head_x_q == X_MAX_C);
            mv_x    = at_wall ? X_MIN_C : head_x_q + X_W'(1);
         end
         DIR_UP: begin
            at_wall = (head_y_q == Y_MIN_C);
            mv_y    = at_wall ? Y_MAX_C : head_y_q - Y_W'(1);
         end
         default: begin
            at_wall = (head_y_q == Y_MAX_C);
            mv_y    = at_wall ? Y_MIN_C : head_y_q + Y_W'(1);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (restart) state_d = S_IDLE;
                  else if (step) state_d = S_CALC;
         S_CALC:  if (wall_over) state_d = S_OVER;
                  else if (chk_count == '0) state_d = S_ERASE;
                  else state_d = S_CHECK;
         S_CHECK: if (seg_match) state_d = S_OVER;
                  else if (chk_left_q == LEN_W'(1)) state_d = S_ERASE;
         S_ERASE: if (grow_q || draw_ready) state_d = S_WRITE;
         S_WRITE: state_d = S_DRAW;
         S_DRAW:  if (draw_ready) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         S_OVER:  if (restart) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dir_d      = dir_q;
      grow_d     = grow_q;
      head_ptr_d = head_ptr_q;
      length_d   = length_q;
      head_x_d   = head_x_q;
      head_y_d   = head_y_q;
      next_x_d   = next_x_q;
      next_y_d   = next_y_q;
      chk_ptr_d  = chk_ptr_q;
      chk_left_d = chk_left_q;
      done_d     = (state_d == S_DONE) || (state_d == S_OVER && state_q != S_OVER);
      if (restart_ok) begin
         dir_d      = DIR_RIGHT;
         grow_d     = 1'b0;
         head_ptr_d = '0;
         length_d   = LEN_W'(1);
         head_x_d   = START_X_C;
         head_y_d   = START_Y_C;
      end else begin
         case (state_q)
            S_IDLE: if (step) begin
               dir_d  = (length_q > LEN_W'(1) && dir == reverse_dir(dir_q)) ? dir_q : dir;
               grow_d = grow && (length_q < MAX_LEN_C);
            end
            S_CALC: begin
               next_x_d   = mv_x;
               next_y_d   = mv_y;
               chk_left_d = chk_count;
               chk_ptr_d  = head_ptr_q - PTR_W'(1);
            end
            S_CHECK: begin
               chk_left_d = chk_left_q - LEN_W'(1);
               chk_ptr_d  = chk_ptr_q - PTR_W'(1);
            end
            S_WRITE: begin
               head_ptr_d = head_ptr_q + PTR_W'(1);
               head_x_d   = next_x_q;
               head_y_d   = next_y_q;
               if (grow_q) length_d = length_q + LEN_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         dir_q      <= DIR_RIGHT;
         grow_q     <= 1'b0;
         head_ptr_q <= '0;
         length_q   <= LEN_W'(1);
         head_x_q   <= START_X_C;
         head_y_q   <= START_Y_C;
         next_x_q   <= '0;
         next_y_q   <= '0;
         chk_ptr_q  <= '0;
         chk_left_q <= '0;
         done_q     <= 1'b0;
      end else begin
         dir_q      <= dir_d;
         grow_q     <= grow_d;
         head_ptr_q <= head_ptr_d;
         length_q   <= length_d;
         head_x_q   <= head_x_d;
         head_y_q   <= head_y_d;
         next_x_q   <= next_x_d;
         next_y_q   <= next_y_d;
         chk_ptr_q  <= chk_ptr_d;
         chk_left_q <= chk_left_d;
         done_q     <= done_d;
      end
   end

   // Reads run one state ahead: the last compare (or CALC with nothing to compare) fetches the tail for ERASE.
   always_comb begin
      rd_addr = tail_ptr;
      if (state_q == S_CALC && chk_count != '0) begin
         rd_addr = head_ptr_q;
      end else if (state_q == S_CHECK && chk_left_q > LEN_W'(1)) begin
         rd_addr = chk_ptr_q;
      end
   end

   assign wr_en   = init || (state_q == S_WRITE);
   assign wr_addr = init ? '0 : head_ptr_q + PTR_W'(1);
   assign wr_data = init ? {START_X_C, START_Y_C} : {next_x_q, next_y_q};

   snake_ring_buf #(
      .DEPTH (MAX_LEN),
      .W     (SEG_W),
      .AW    (PTR_W)
   ) u_ring (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_comb begin
      busy        = (state_q != S_IDLE) && (state_q != S_OVER);
      over        = (state_q == S_OVER);
      done        = done_q;
      length      = length_q;
      head_x      = head_x_q;
      head_y      = head_y_q;
      draw_valid  = 1'b0;
      draw_x      = '0;
      draw_y      = '0;
      draw_colour = '0;
      if (state_q == S_ERASE && !grow_q) begin
         draw_valid  = 1'b1;
         draw_x      = rd_data[SEG_W-1:Y_W];
         draw_y      = rd_data[Y_W-1:0];
         draw_colour = BG_COLOUR;
      end else if (state_q == S_DRAW) begin
         draw_valid  = 1'b1;
         draw_x      = head_x_q;
         draw_y      = head_y_q;
         draw_colour = HEAD_COLOUR;
      end
   end

endmodule
`default_nettype wire
